// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default sizes for the cache/memory arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

    localparam int c_addr_w  = 6;
    localparam int c_data_w  = 32;
    localparam int c_timeout = 255;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// =============================================================================
// Module      : mem_arb_watchdog
// Description : Saturating busy-cycle counter with a sticky over-threshold flag.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_err
);

    localparam int c_cnt_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_err;

    // Counter saturates at TIMEOUT; the flag only clears on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_cnt_w'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
            if (r_count == c_cnt_w'(TIMEOUT - 1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between I and D caches.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = c_addr_w,
    parameter int DATA_W  = c_data_w,
    parameter int TIMEOUT = c_timeout
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_seen_busy;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [DATA_W-1:0] r_i_readdata;
    logic [DATA_W-1:0] r_d_readdata;

    logic w_d_req;
    logic w_granted;
    logic w_done;
    logic w_pick_i;
    logic w_grant_start;

    assign w_d_req       = d_read | d_write;
    assign w_granted     = (r_state == GRANT_I) || (r_state == GRANT_D);
    // A grant only completes after memory has acknowledged it by going busy.
    assign w_done        = w_granted && r_seen_busy && !mem_busywait;
    assign w_pick_i      = i_read && (!w_d_req || (r_last_grant == REQ_D));
    assign w_grant_start = (r_state == IDLE) && (i_read || w_d_req);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_last_grant    <= REQ_D;
            r_seen_busy     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_start) begin
                        r_seen_busy <= 1'b0;
                        if (w_pick_i) begin
                            r_state         <= GRANT_I;
                            r_last_grant    <= REQ_I;
                            r_mem_read      <= 1'b1;
                            r_mem_write     <= 1'b0;
                            r_mem_address   <= i_address;
                            r_mem_writedata <= '0;
                        end else begin
                            // A simultaneous read+write from the dcache is a write-back.
                            r_state         <= GRANT_D;
                            r_last_grant    <= REQ_D;
                            r_mem_read      <= ~d_write;
                            r_mem_write     <= d_write;
                            r_mem_address   <= d_address;
                            r_mem_writedata <= d_writedata;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (mem_busywait) begin
                        r_seen_busy <= 1'b1;
                    end
                    if (w_done) begin
                        r_state     <= RELEASE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_state == GRANT_I) begin
                            r_i_readdata <= mem_readdata;
                        end else begin
                            r_d_readdata <= mem_readdata;
                        end
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        i_busywait = i_read;
        d_busywait = w_d_req;
        i_readdata = r_i_readdata;
        d_readdata = r_d_readdata;
        if (r_state == GRANT_I) begin
            i_busywait = ~w_done;
            if (w_done) begin
                i_readdata = mem_readdata;
            end
        end
        if (r_state == GRANT_D) begin
            d_busywait = ~w_done;
            if (w_done) begin
                d_readdata = mem_readdata;
            end
        end
    end

    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_writedata = r_mem_writedata;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .i_en  (w_granted),
        .i_clr (w_grant_start),
        .o_err (timeout_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a latency memory model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [DATA_W-1:0] d_writedata = '0;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic              mem_busywait = 1'b0;
    logic              timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (255)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    // Memory model: busy for mem_lat negedges after a command appears, then ready.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } iss_t;

    iss_t        iss_q[$];
    int          mem_lat = 5;
    int          mem_cnt = 0;
    logic [31:0] mem_rdata_cfg = 32'h0;

    always @(negedge clock) begin
        if (!(mem_read || mem_write)) begin
            mem_busywait = 1'b0;
            mem_cnt      = 0;
        end else begin
            if (mem_cnt == 0) iss_q.push_back({mem_write, mem_address, mem_writedata});
            mem_busywait = (mem_cnt < mem_lat);
            mem_readdata = mem_rdata_cfg;
            mem_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
    endtask

    // Waits for the selected requester's busywait to drop; counts other-side lows.
    task automatic wait_done(input bit is_d, input int budget, output bit ok,
                             output int other_low, output int waited);
        ok        = 1'b0;
        other_low = 0;
        waited    = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            #1;
            waited++;
            if ((is_d ? d_busywait : i_busywait) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            if ((is_d ? i_busywait : d_busywait) == 1'b0) other_low++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read got=%b exp=0", mem_read); else n_pass++;
        n_checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got=%b exp=0", mem_write); else n_pass++;
        n_checks++; if (mem_address !== 6'h00) $display("FAIL rst_mem_address got=%h exp=00", mem_address); else n_pass++;
        n_checks++; if (mem_writedata !== 32'h0) $display("FAIL rst_mem_writedata got=%h exp=0", mem_writedata); else n_pass++;
        n_checks++; if ({i_busywait, d_busywait} !== 2'b00) $display("FAIL rst_busywait got=%b exp=00", {i_busywait, d_busywait}); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); else n_pass++;
        n_checks++; if ({i_readdata, d_readdata} !== 64'h0) $display("FAIL rst_readdata got=%h exp=0", {i_readdata, d_readdata}); else n_pass++;
    endtask

    task automatic test_icache_read();
        bit ok; int ol; int w;
        mem_lat = 5;
        mem_rdata_cfg = 32'hDEADBEEF;
        i_read = 1'b1;
        i_address = 6'h15;
        #1;
        n_checks++; if (i_busywait !== 1'b1) $display("FAIL iread_busy_idle got=%b exp=1", i_busywait); else n_pass++;
        tick();
        n_checks++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL iread_cmd got=%b exp=10", {mem_read, mem_write}); else n_pass++;
        n_checks++; if (mem_address !== 6'h15) $display("FAIL iread_addr got=%h exp=15", mem_address); else n_pass++;
        wait_done(1'b0, 30, ok, ol, w);
        n_checks++; if (ok !== 1'b1) $display("FAIL iread_done got=%b exp=1", ok); else n_pass++;
        n_checks++; if (w !== 6) $display("FAIL iread_latency got=%0d exp=6", w); else n_pass++;
        n_checks++; if (i_readdata !== 32'hDEADBEEF) $display("FAIL iread_data got=%h exp=deadbeef", i_readdata); else n_pass++;
        n_checks++; if (d_busywait !== 1'b0) $display("FAIL iread_d_busy got=%b exp=0", d_busywait); else n_pass++;
        i_read = 1'b0;
        tick();
        n_checks++; if ({mem_read, i_busywait} !== 2'b00) $display("FAIL iread_release got=%b exp=00", {mem_read, i_busywait}); else n_pass++;
        n_checks++; if (i_readdata !== 32'hDEADBEEF) $display("FAIL iread_data_reg got=%h exp=deadbeef", i_readdata); else n_pass++;
        tick();
    endtask

    task automatic test_contested();
        bit ok; int ol; int w;
        iss_t exp0, exp1, got0, got1;
        do_reset();
        iss_q.delete();
        mem_lat = 3;
        mem_rdata_cfg = 32'hA5A5A5A5;
        i_read = 1'b1;       i_address = 6'h03;
        d_write = 1'b1;      d_address = 6'h2A;  d_writedata = 32'h12345678;
        wait_done(1'b0, 30, ok, ol, w);
        n_checks++; if (ok !== 1'b1) $display("FAIL cont_i_done got=%b exp=1", ok); else n_pass++;
        n_checks++; if (ol !== 0 || d_busywait !== 1'b1) $display("FAIL cont_d_stall got_lows=%0d busy=%b exp=0/1", ol, d_busywait); else n_pass++;
        i_read = 1'b0;
        wait_done(1'b1, 30, ok, ol, w);
        n_checks++; if (ok !== 1'b1) $display("FAIL cont_d_done got=%b exp=1", ok); else n_pass++;
        d_write = 1'b0;
        exp0 = {1'b0, 6'h03, 32'h0};
        exp1 = {1'b1, 6'h2A, 32'h12345678};
        got0 = (iss_q.size() > 0) ? iss_q[0] : '0;
        got1 = (iss_q.size() > 1) ? iss_q[1] : '0;
        n_checks++; if (got0 !== exp0) $display("FAIL cont_first got=%h exp=%h", got0, exp0); else n_pass++;
        n_checks++; if (got1 !== exp1) $display("FAIL cont_second got=%h exp=%h", got1, exp1); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        logic [17:0] got;
        iss_q.delete();
        mem_lat = 2;
        i_read = 1'b1;  i_address = 6'h01;
        d_read = 1'b1;  d_address = 6'h02;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            #1;
            if (iss_q.size() >= 3) break;
        end
        i_read = 1'b0;
        d_read = 1'b0;
        repeat (15) tick();
        got = '0;
        for (int k = 0; k < 3; k++) begin
            if (iss_q.size() > k) got[17-6*k -: 6] = iss_q[k].addr;
        end
        n_checks++; if (got !== {6'h01, 6'h02, 6'h01}) $display("FAIL rr_order got=%h exp=%h", got, {6'h01, 6'h02, 6'h01}); else n_pass++;
        n_checks++; if (iss_q.size() !== 3) $display("FAIL rr_count got=%0d exp=3", iss_q.size()); else n_pass++;
    endtask

    task automatic test_addr_change();
        int bad;
        bit ok;
        iss_q.delete();
        mem_lat = 6;
        i_read = 1'b1;
        i_address = 6'h03;
        tick();
        i_address = 6'h3F;
        bad = 0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            #1;
            if (mem_address !== 6'h03) bad++;
            if (!i_busywait) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (ok !== 1'b1 || bad !== 0) $display("FAIL addr_hold done=%b bad_cycles=%0d exp=1/0", ok, bad); else n_pass++;
        i_read = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        int rise_at;
        bit ok; int ol; int w;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_pre got=%b exp=0", timeout_err); else n_pass++;
        mem_lat = 300;
        i_read = 1'b1;
        i_address = 6'h0A;
        tick();
        rise_at = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (timeout_err) begin
                rise_at = k;
                break;
            end
        end
        n_checks++; if (rise_at !== 255) $display("FAIL to_rise_cycle got=%0d exp=255", rise_at); else n_pass++;
        wait_done(1'b0, 200, ok, ol, w);
        n_checks++; if (ok !== 1'b1) $display("FAIL to_done got=%b exp=1", ok); else n_pass++;
        i_read = 1'b0;
        repeat (3) tick();
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", timeout_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok; int ol; int w;
        iss_t got0;
        mem_lat = 20;
        d_write = 1'b1;  d_address = 6'h11;  d_writedata = 32'hCAFEF00D;
        repeat (3) tick();
        n_checks++; if (mem_write !== 1'b1) $display("FAIL rmid_active got=%b exp=1", mem_write); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if ({mem_write, mem_read} !== 2'b00) $display("FAIL rmid_cmd_drop got=%b exp=00", {mem_write, mem_read}); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL rmid_err_clr got=%b exp=0", timeout_err); else n_pass++;
        d_write = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if ({i_busywait, d_busywait} !== 2'b00) $display("FAIL rmid_idle got=%b exp=00", {i_busywait, d_busywait}); else n_pass++;
        iss_q.delete();
        mem_lat = 2;
        i_read = 1'b1;  i_address = 6'h05;
        d_read = 1'b1;  d_address = 6'h06;
        wait_done(1'b0, 30, ok, ol, w);
        i_read = 1'b0;
        got0 = (iss_q.size() > 0) ? iss_q[0] : '0;
        n_checks++; if (ok !== 1'b1 || got0.addr !== 6'h05) $display("FAIL rmid_first_grant done=%b addr=%h exp=1/05", ok, got0.addr); else n_pass++;
        wait_done(1'b1, 30, ok, ol, w);
        d_read = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_both_dcache();
        bit ok; int ol; int w;
        iss_t got0, exp0;
        iss_q.delete();
        mem_lat = 2;
        d_read = 1'b1;  d_write = 1'b1;  d_address = 6'h2B;  d_writedata = 32'h0BADF00D;
        wait_done(1'b1, 30, ok, ol, w);
        d_read = 1'b0;
        d_write = 1'b0;
        exp0 = {1'b1, 6'h2B, 32'h0BADF00D};
        got0 = (iss_q.size() > 0) ? iss_q[0] : '0;
        n_checks++; if (ok !== 1'b1 || got0 !== exp0) $display("FAIL both_as_write done=%b got=%h exp=%h", ok, got0, exp0); else n_pass++;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_contested();
        test_round_robin();
        test_addr_change();
        test_both_dcache();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
